// File: rtl/traffic_light_monitor_pkg.sv
// Shared encodings for the traffic light controller and its checkers:
// phase codes, one-hot light codes and default phase dwell lengths.
package traffic_light_monitor_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_UNSYNC = 2'b11
    } phase_t;

    // Light bus bit order is {Red, Yellow, Green}
    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_GREEN  = 3'b001;

    localparam int DEF_RED_CYCLES    = 6;
    localparam int DEF_GREEN_CYCLES  = 6;
    localparam int DEF_YELLOW_CYCLES = 3;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:    next_phase = PH_GREEN;
            PH_GREEN:  next_phase = PH_YELLOW;
            PH_YELLOW: next_phase = PH_RED;
            default:   next_phase = PH_UNSYNC;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational light-bus decoder: maps a one-hot light code to its phase
// and flags any pattern that is not exactly one lamp lit.
module traffic_light_decode
    import traffic_light_monitor_pkg::*;
(
    input  logic [2:0] i_light,
    output logic       o_valid,
    output phase_t     o_phase
);

    always_comb begin
        o_valid = 1'b1;
        o_phase = PH_UNSYNC;
        case (i_light)
            LT_RED:    o_phase = PH_RED;
            LT_GREEN:  o_phase = PH_GREEN;
            LT_YELLOW: o_phase = PH_YELLOW;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light bus: tracks the phase, flags one-hot,
// ordering and dwell violations, and counts clean R->G->Y->R rounds.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int RED_CYCLES    = DEF_RED_CYCLES,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int DWELL_W       = 4,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         light,
    input  logic               clr_err,
    output logic [1:0]         phase,
    output logic               locked,
    output logic [DWELL_W-1:0] dwell,
    output logic               err_onehot,
    output logic               err_seq,
    output logic               err_dwell,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam logic [DWELL_W:0]   LIM_RED    = (DWELL_W+1)'(RED_CYCLES);
    localparam logic [DWELL_W:0]   LIM_GREEN  = (DWELL_W+1)'(GREEN_CYCLES);
    localparam logic [DWELL_W:0]   LIM_YELLOW = (DWELL_W+1)'(YELLOW_CYCLES);
    localparam logic [DWELL_W:0]   ONE_W      = (DWELL_W+1)'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    phase_t             r_state, r_state_next;
    logic [DWELL_W-1:0] r_dwell, r_dwell_next;
    logic               r_checked, r_checked_next;
    logic               r_overrun, r_overrun_next;
    logic               r_good, r_good_next;
    logic               r_err_onehot, r_err_onehot_next;
    logic               r_err_seq, r_err_seq_next;
    logic               r_err_dwell, r_err_dwell_next;
    logic               r_err_pulse, r_err_pulse_next;
    logic [CNT_W-1:0]   r_cycle_cnt, r_cycle_cnt_next;

    logic               w_valid;
    phase_t             w_phase;
    logic [DWELL_W:0]   w_limit;
    logic [DWELL_W:0]   w_dwell_inc;
    logic               w_new_onehot;
    logic               w_new_seq;
    logic               w_new_dwell;
    logic               w_any_err;

    traffic_light_decode u_decode (
        .i_light (light),
        .o_valid (w_valid),
        .o_phase (w_phase)
    );

    always_comb begin
        case (r_state)
            PH_RED:    w_limit = LIM_RED;
            PH_GREEN:  w_limit = LIM_GREEN;
            PH_YELLOW: w_limit = LIM_YELLOW;
            default:   w_limit = '0;
        endcase
    end

    assign w_dwell_inc = {1'b0, r_dwell} + ONE_W;

    always_comb begin
        r_state_next     = r_state;
        r_dwell_next     = r_dwell;
        r_checked_next   = r_checked;
        r_overrun_next   = r_overrun;
        r_good_next      = r_good;
        r_cycle_cnt_next = r_cycle_cnt;
        w_new_onehot     = 1'b0;
        w_new_seq        = 1'b0;
        w_new_dwell      = 1'b0;

        if (r_state == PH_UNSYNC) begin
            if (w_valid) begin
                r_state_next   = w_phase;
                r_dwell_next   = DWELL_ONE;
                r_checked_next = 1'b0;
                r_overrun_next = 1'b0;
                r_good_next    = 1'b0;
            end else begin
                w_new_onehot = 1'b1;
            end
        end else if (!w_valid) begin
            w_new_onehot   = 1'b1;
            r_state_next   = PH_UNSYNC;
            r_dwell_next   = '0;
            r_checked_next = 1'b0;
            r_overrun_next = 1'b0;
            r_good_next    = 1'b0;
        end else if (w_phase == r_state) begin
            r_dwell_next = (&r_dwell) ? r_dwell : w_dwell_inc[DWELL_W-1:0];
            if ((w_dwell_inc > w_limit) && !r_overrun) begin
                w_new_dwell    = 1'b1;
                r_overrun_next = 1'b1;
            end
        end else if (w_phase == next_phase(r_state)) begin
            if (r_checked && ({1'b0, r_dwell} != w_limit))
                w_new_dwell = 1'b1;
            r_state_next   = w_phase;
            r_dwell_next   = DWELL_ONE;
            r_checked_next = 1'b1;
            r_overrun_next = 1'b0;
            // A round only counts if its RED was itself entered cleanly from a checked YELLOW
            if (r_state == PH_YELLOW) begin
                r_good_next = r_checked && ({1'b0, r_dwell} == w_limit);
                if (r_good_next && r_good && !(&r_cycle_cnt))
                    r_cycle_cnt_next = r_cycle_cnt + CNT_ONE;
            end
        end else begin
            w_new_seq      = 1'b1;
            r_state_next   = w_phase;
            r_dwell_next   = DWELL_ONE;
            r_checked_next = 1'b0;
            r_overrun_next = 1'b0;
        end

        w_any_err = w_new_onehot | w_new_seq | w_new_dwell;
        if (w_any_err)
            r_good_next = 1'b0;

        // A fresh error on the same edge as clr_err keeps its flag set
        r_err_onehot_next = w_new_onehot | (r_err_onehot & ~clr_err);
        r_err_seq_next    = w_new_seq    | (r_err_seq    & ~clr_err);
        r_err_dwell_next  = w_new_dwell  | (r_err_dwell  & ~clr_err);
        r_err_pulse_next  = w_any_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PH_UNSYNC;
            r_dwell      <= '0;
            r_checked    <= 1'b0;
            r_overrun    <= 1'b0;
            r_good       <= 1'b0;
            r_err_onehot <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_dwell  <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_cycle_cnt  <= '0;
        end else begin
            r_state      <= r_state_next;
            r_dwell      <= r_dwell_next;
            r_checked    <= r_checked_next;
            r_overrun    <= r_overrun_next;
            r_good       <= r_good_next;
            r_err_onehot <= r_err_onehot_next;
            r_err_seq    <= r_err_seq_next;
            r_err_dwell  <= r_err_dwell_next;
            r_err_pulse  <= r_err_pulse_next;
            r_cycle_cnt  <= r_cycle_cnt_next;
        end
    end

    assign phase      = r_state;
    assign locked     = (r_state != PH_UNSYNC);
    assign dwell      = r_dwell;
    assign err_onehot = r_err_onehot;
    assign err_seq    = r_err_seq;
    assign err_dwell  = r_err_dwell;
    assign err_pulse  = r_err_pulse;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive protocol checker on the 3-bit light bus driven by the team's traffic light controller: light[2]=Red, light[1]=Yellow, light[0]=Green.
It decodes the bus back into a phase, checks one-hot encoding, the RED→GREEN→YELLOW→RED order, and per-phase dwell times.
It reports sticky error flags, a per-error strobe, and a count of completed good cycles.
It sits beside the controller in the top level and in the testbench, and never drives the light bus.

Parameters:
RED_CYCLES, 6, required consecutive clk samples of RED per phase
GREEN_CYCLES, 6, required consecutive samples of GREEN
YELLOW_CYCLES, 3, required consecutive samples of YELLOW
DWELL_W, 4, dwell counter width; must hold max(*_CYCLES)+1
CNT_W, 16, width of completed-cycle counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
light  input  3  monitored bus {Red,Yellow,Green}
clr_err  input  1  synchronous clear of sticky error flags
phase  output  2  decoded phase: 00 RED, 01 GREEN, 10 YELLOW, 11 UNSYNC
locked  output  1  1 when phase != UNSYNC
dwell  output  DWELL_W  samples seen in current phase, saturating
err_onehot  output  1  sticky: light not one of 100/010/001
err_seq  output  1  sticky: illegal phase transition
err_dwell  output  1  sticky: phase ended early or overran its limit
err_pulse  output  1  one-cycle strobe on any new error event
cycle_cnt  output  CNT_W  completed good R→G→Y→R cycles, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. No asynchronous paths.
- Reset values: phase=11 (UNSYNC), locked=0, dwell=0, all err_* =0, err_pulse=0, cycle_cnt=0, internal checked flag=0.
- FSM states: UNSYNC, RED, GREEN, YELLOW. The state encoding equals the phase output.
- Latency: light is sampled on each edge. All outputs are registered, so an event on the sampled light appears on the outputs 1 cycle later.
- UNSYNC:
  - Legal one-hot light: enter the matching phase with dwell=1 and checked=0. The phase was entered mid-stream, so its early-end check is skipped.
  - Illegal light: stay in UNSYNC. err_onehot is set and err_pulse fires.
- Locked phase P, light still encodes P:
  - dwell <= dwell+1, saturating at all-ones.
  - If dwell+1 > *_CYCLES(P) and no overrun has yet been flagged in this phase: set err_dwell and pulse once.
  - The FSM stays in P.
- Locked phase P, light is the legal successor (RED→GREEN, GREEN→YELLOW, YELLOW→RED):
  - If checked=1 and dwell != *_CYCLES(P): err_dwell set and pulse.
  - Enter the successor with dwell=1 and checked=1.
  - If the transition is YELLOW→RED with checked=1 and dwell==YELLOW_CYCLES, cycle_cnt increments (saturating) when no error occurred since entering RED from a checked transition.
- Locked phase, light is a legal one-hot but not the successor (e.g. RED→YELLOW, GREEN→RED): err_seq set and pulse. Resync: enter the new phase with dwell=1 and checked=0.
- Locked phase, illegal light (000, 011, 101, 110, 111): err_onehot set and pulse. Go to UNSYNC with dwell=0.
- Multiple errors on one edge: only one can occur per edge by construction. err_pulse is a single cycle regardless.
- clr_err: clears err_onehot, err_seq and err_dwell. If a new error occurs on the same edge, the new error wins (flag set).
- clr_err does not affect the FSM, dwell or cycle_cnt.
- Reset mid-phase: all state is discarded and the FSM returns to UNSYNC. The next phase is partial (checked=0).

Decomposition:
- Shared package holds:
  - phase encoding constants (PH_RED=00, PH_GREEN=01, PH_YELLOW=10, PH_UNSYNC=11);
  - light encoding constants (LT_RED=100, LT_YELLOW=010, LT_GREEN=001);
  - default dwell constants (6, 6, 3), also used by the controller.
- One natural sub-module, traffic_light_decode: combinational light→{valid, phase} decoder, reused by other checkers.

Test Plan:
- Reset the monitor together with a free-running controller, run 60 cycles (4 full 15-cycle rounds) → no err_*. cycle_cnt=3: the first RED is partial. locked=1 from cycle 2.
- Drive RED×6, GREEN×6, YELLOW×2, RED → err_dwell=1 and err_pulse high for exactly 1 cycle. cycle_cnt unchanged.
- Drive RED×6, then YELLOW → err_seq=1. Phase becomes 10. Subsequent YELLOW×3→RED raises no further error.
- Drive light=110 while GREEN → err_onehot=1 and phase=11. Then light=001 → phase=01, locked=1.
- Hold GREEN for 20 cycles → err_dwell set once at the 7th sample. dwell saturates at 15. err_pulse fires once.
- Assert clr_err with a coincident dwell overrun → err_dwell stays 1. clr_err alone next cycle → all flags 0.
